ltl_monitor_cluster: RTL and testbench

Parametrised aggregation and bookkeeping stage for a cluster of LTL runtime-monitor automata. Per property, it ORs that property's automaton report bits and gates them with `run` and a per-property enable mask. It then registers a per-cycle violation flag and keeps three records: a sticky flag, a saturating violation count, and a capture of the first violation (property, symbol, time stamp). It sits between the automata stages of a monitor cluster and the core-side status/readout logic. It replaces the fixed-width, purely combinational OR fan-in of earlier clusters.

---
 rtl/ltl_monitor_cluster.sv | 129 ++++++++++++
 tb/tb_ltl_monitor_cluster.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ltl_monitor_cluster.sv
// Violation aggregation and bookkeeping for a cluster of LTL monitor automata.
// Optional time stamping of the first violation is enabled with LTL_MON_STAMP_EN.
module ltl_monitor_cluster #(
    parameter int SYM_W        = 8,
    parameter int NUM_PROP     = 7,
    parameter int RPT_PER_PROP = 4,
    parameter int CNT_W        = 16,
    parameter int STAMP_W      = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             run,
    input  logic [SYM_W-1:0]                 symbols,
    input  logic [NUM_PROP*RPT_PER_PROP-1:0] reports,
    input  logic [NUM_PROP-1:0]              prop_en,
    input  logic                             clear,
    input  logic [$clog2(NUM_PROP)-1:0]      rd_sel,
    output logic [NUM_PROP-1:0]              ltl,
    output logic [NUM_PROP-1:0]              ltl_sticky,
    output logic                             any_violation,
    output logic [CNT_W-1:0]                 rd_count,
    output logic                             first_valid,
    output logic [$clog2(NUM_PROP)-1:0]      first_prop,
    output logic [SYM_W-1:0]                 first_symbol,
    output logic [STAMP_W-1:0]               first_stamp
);

    localparam int SEL_W = $clog2(NUM_PROP);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [NUM_PROP-1:0] hit_p0;
    logic [SEL_W-1:0]    hit_idx_p0;
    logic                rec_load_p0;

    logic [NUM_PROP-1:0] ltl_p1, sticky_p1, sticky_nxt;
    logic [CNT_W-1:0]    count_p1 [NUM_PROP];
    logic [CNT_W-1:0]    count_nxt [NUM_PROP];
    logic [CNT_W-1:0]    rd_p1, rd_nxt;
    logic                fv_p1, fv_nxt;
    logic [SEL_W-1:0]    fp_p1, fp_nxt;
    logic [SYM_W-1:0]    fs_p1, fs_nxt;

    // Stage 0: per-property violation terms and lowest-index hit
    always_comb begin
        hit_p0     = '0;
        hit_idx_p0 = '0;
        for (int p = 0; p < NUM_PROP; p++)
            hit_p0[p] = run & prop_en[p] & (|reports[p*RPT_PER_PROP +: RPT_PER_PROP]);
        for (int p = NUM_PROP - 1; p >= 0; p--)
            if (hit_p0[p]) hit_idx_p0 = SEL_W'(p);
    end

    always_comb begin
        sticky_nxt  = (clear ? '0 : sticky_p1) | hit_p0;
        fv_nxt      = clear ? 1'b0 : fv_p1;
        fp_nxt      = clear ? '0 : fp_p1;
        fs_nxt      = clear ? '0 : fs_p1;
        rec_load_p0 = ~fv_nxt & (|hit_p0);
        if (rec_load_p0) begin
            fv_nxt = 1'b1;
            fp_nxt = hit_idx_p0;
            fs_nxt = symbols;
        end
        // Readout sees counters as they were before this edge's update
        rd_nxt = '0;
        for (int p = 0; p < NUM_PROP; p++) begin
            count_nxt[p] = clear ? '0 : count_p1[p];
            if (hit_p0[p]) count_nxt[p] = sat_inc(count_nxt[p]);
            if (rd_sel == SEL_W'(p)) rd_nxt = count_p1[p];
        end
    end

    // Stage 1: registered flags, counters and first-violation record
    always_ff @(posedge clk) begin
        if (reset) begin
            ltl_p1    <= '0;
            sticky_p1 <= '0;
            rd_p1     <= '0;
            fv_p1     <= 1'b0;
            fp_p1     <= '0;
            fs_p1     <= '0;
            for (int p = 0; p < NUM_PROP; p++) count_p1[p] <= '0;
        end else begin
            ltl_p1    <= hit_p0;
            sticky_p1 <= sticky_nxt;
            rd_p1     <= rd_nxt;
            fv_p1     <= fv_nxt;
            fp_p1     <= fp_nxt;
            fs_p1     <= fs_nxt;
            for (int p = 0; p < NUM_PROP; p++) count_p1[p] <= count_nxt[p];
        end
    end

`ifdef LTL_MON_STAMP_EN
    logic [STAMP_W-1:0] stamp_p1, stamp_now_p0, fst_p1, fst_nxt;

    always_comb begin
        stamp_now_p0 = clear ? '0 : stamp_p1;
        fst_nxt      = clear ? '0 : fst_p1;
        if (rec_load_p0) fst_nxt = stamp_now_p0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stamp_p1 <= '0;
            fst_p1   <= '0;
        end else begin
            stamp_p1 <= stamp_now_p0 + STAMP_W'(run);
            fst_p1   <= fst_nxt;
        end
    end

    assign first_stamp = fst_p1;
`else
    assign first_stamp = '0;
`endif

    assign ltl           = ltl_p1;
    assign ltl_sticky    = sticky_p1;
    assign any_violation = |sticky_p1;
    assign rd_count      = rd_p1;
    assign first_valid   = fv_p1;
    assign first_prop    = fp_p1;
    assign first_symbol  = fs_p1;

endmodule

// File: tb/tb_ltl_monitor_cluster.sv
// Scoreboard bench for ltl_monitor_cluster (CNT_W=4 so saturation is reachable).
module tb_ltl_monitor_cluster;

    localparam int NP = 7;
    localparam int RP = 4;
    localparam int SW = 8;
    localparam int CW = 4;
    localparam int TW = 32;
    localparam int SL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, run, clear;
    logic [SW-1:0]    symbols;
    logic [NP*RP-1:0] reports;
    logic [NP-1:0]    prop_en;
    logic [SL-1:0]    rd_sel;
    logic [NP-1:0]    ltl, ltl_sticky;
    logic             any_violation, first_valid;
    logic [CW-1:0]    rd_count;
    logic [SL-1:0]    first_prop;
    logic [SW-1:0]    first_symbol;
    logic [TW-1:0]    first_stamp;

    ltl_monitor_cluster #(
        .SYM_W(SW), .NUM_PROP(NP), .RPT_PER_PROP(RP), .CNT_W(CW), .STAMP_W(TW)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .symbols(symbols), .reports(reports),
        .prop_en(prop_en), .clear(clear), .rd_sel(rd_sel), .ltl(ltl),
        .ltl_sticky(ltl_sticky), .any_violation(any_violation), .rd_count(rd_count),
        .first_valid(first_valid), .first_prop(first_prop), .first_symbol(first_symbol),
        .first_stamp(first_stamp)
    );

    typedef struct packed {
        logic [NP-1:0] ltl;
        logic [NP-1:0] sticky;
        logic          any;
        logic [CW-1:0] rd;
        logic          fv;
        logic [SL-1:0] fp;
        logic [SW-1:0] fs;
        logic [TW-1:0] fst;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    logic [NP-1:0] m_sticky;
    logic [CW-1:0] m_cnt [NP];
    logic [TW-1:0] m_stamp;
    logic          m_fv;
    logic [SL-1:0] m_fp;
    logic [SW-1:0] m_fs;
    logic [TW-1:0] m_fst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [NP*RP-1:0] rb(input int p, input int b);
        logic [NP*RP-1:0] v;
        v = '0;
        v[p*RP+b] = 1'b1;
        return v;
    endfunction

    // Monitor: one expectation per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ltl", 64'(ltl), 64'(e.ltl));
                chk("ltl_sticky", 64'(ltl_sticky), 64'(e.sticky));
                chk("any_violation", 64'(any_violation), 64'(e.any));
                chk("rd_count", 64'(rd_count), 64'(e.rd));
                chk("first_valid", 64'(first_valid), 64'(e.fv));
                chk("first_prop", 64'(first_prop), 64'(e.fp));
                chk("first_symbol", 64'(first_symbol), 64'(e.fs));
                chk("first_stamp", 64'(first_stamp), 64'(e.fst));
            end
        end
    end

    task automatic step(input logic r, input logic [SW-1:0] s, input logic [NP*RP-1:0] rep,
                        input logic [NP-1:0] en, input logic c, input logic [SL-1:0] sel,
                        input logic rs);
        exp_t e;
        logic [NP-1:0] h;
        int lo;
        @(negedge clk);
        run = r; symbols = s; reports = rep; prop_en = en; clear = c; rd_sel = sel; reset = rs;
        e = '0;
        if (rs) begin
            m_sticky = '0; m_stamp = '0; m_fv = 1'b0; m_fp = '0; m_fs = '0; m_fst = '0;
            for (int p = 0; p < NP; p++) m_cnt[p] = '0;
        end else begin
            h = '0;
            for (int p = 0; p < NP; p++) h[p] = r && en[p] && (rep[p*RP +: RP] != '0);
            e.rd = (int'(sel) < NP) ? m_cnt[int'(sel)] : '0;
            if (c) begin
                m_sticky = '0; m_stamp = '0; m_fv = 1'b0; m_fp = '0; m_fs = '0; m_fst = '0;
                for (int p = 0; p < NP; p++) m_cnt[p] = '0;
            end
            for (int p = 0; p < NP; p++)
                if (h[p]) begin
                    m_sticky[p] = 1'b1;
                    if (m_cnt[p] != 4'hF) m_cnt[p] = m_cnt[p] + 4'd1;
                end
            if (!m_fv && h != '0) begin
                lo = -1;
                for (int p = 0; p < NP; p++) if (h[p] && lo < 0) lo = p;
                m_fv = 1'b1;
                m_fp = SL'(lo);
                m_fs = s;
`ifdef LTL_MON_STAMP_EN
                m_fst = m_stamp;
`else
                m_fst = '0;
`endif
            end
            if (r) m_stamp = m_stamp + 32'd1;
            e.ltl = h; e.sticky = m_sticky; e.any = |m_sticky;
            e.fv = m_fv; e.fp = m_fp; e.fs = m_fs; e.fst = m_fst;
        end
        sb.push_back(e);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; clear = 1'b0; symbols = '0; reports = '0;
        prop_en = '0; rd_sel = '0;
        step(0, 8'h00, '0, 7'h00, 0, 3'd0, 1);
        step(0, 8'h00, '0, 7'h00, 0, 3'd0, 1);
        // Quiet run: stamps 0..6
        for (int i = 0; i < 7; i++) step(1, 8'h00, '0, 7'h7F, 0, SL'(i), 0);
        // p2 and p5 together at stamp 7
        step(1, 8'hA5, rb(2, 0) | rb(5, 3), 7'h7F, 0, 3'd2, 0);
        step(1, 8'h00, '0, 7'h7F, 0, 3'd2, 0);
        step(1, 8'h00, '0, 7'h7F, 0, 3'd5, 0);
        // Later p0 hit must not disturb the record
        step(1, 8'h3C, rb(0, 1), 7'h7F, 0, 3'd0, 0);
        step(1, 8'h00, '0, 7'h7F, 0, 3'd0, 0);
        step(1, 8'h00, '0, 7'h7F, 0, 3'd0, 0);
        // p1 held while run toggles 1,0,1,1
        step(1, 8'h01, rb(1, 2), 7'h7F, 0, 3'd1, 0);
        step(0, 8'h02, rb(1, 2), 7'h7F, 0, 3'd1, 0);
        step(1, 8'h03, rb(1, 2), 7'h7F, 0, 3'd1, 0);
        step(1, 8'h04, rb(1, 2), 7'h7F, 0, 3'd1, 0);
        step(0, 8'h00, '0, 7'h7F, 0, 3'd1, 0);
        step(0, 8'h00, '0, 7'h7F, 0, 3'd1, 0);
        // p3 saturation
        for (int i = 0; i < 20; i++) step(1, 8'h00, rb(3, i % RP), 7'h7F, 0, 3'd3, 0);
        for (int i = 0; i < 3; i++) step(1, 8'h00, '0, 7'h7F, 0, 3'd3, 0);
        // clear with a simultaneous p4 hit
        step(1, 8'h44, rb(4, 1), 7'h7F, 1, 3'd4, 0);
        for (int i = 0; i < 8; i++) step(1, 8'h00, '0, 7'h7F, 0, SL'(i), 0);
        // p0 masked, then re-enabled
        for (int i = 0; i < 3; i++) step(1, 8'h55, rb(0, 0), 7'h7E, 0, 3'd0, 0);
        step(1, 8'h56, rb(0, 0), 7'h7F, 0, 3'd0, 0);
        step(1, 8'h00, '0, 7'h7F, 0, 3'd0, 0);
        step(1, 8'h00, '0, 7'h7F, 0, 3'd0, 0);
        // run low suppresses everything; clear without run
        step(0, 8'hFF, '1, 7'h7F, 0, 3'd1, 0);
        step(0, 8'h00, '0, 7'h7F, 1, 3'd4, 0);
        step(1, 8'h00, '0, 7'h7F, 0, 3'd4, 0);
        // reset mid-run, hit presented during the reset cycle is discarded
        step(1, 8'h11, rb(6, 3), 7'h7F, 0, 3'd6, 0);
        step(1, 8'h22, rb(6, 3), 7'h7F, 0, 3'd6, 1);
        step(1, 8'h00, '0, 7'h7F, 0, 3'd6, 0);
        step(1, 8'h33, rb(6, 0), 7'h7F, 0, 3'd6, 0);
        step(1, 8'h00, '0, 7'h7F, 0, 3'd6, 0);
        step(1, 8'h00, '0, 7'h7F, 0, 3'd6, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
